// File: rtl/fdd_sector_server.sv
// fdd_sector_server: serves WD2793 sector reads/writes from a mounted SD disk image.
// Holds one sector between the MiSTer SD block handshake and the FDC byte stream.
module fdd_sector_server #(
  parameter int SECTOR_BYTES      = 512,
  parameter int SECTORS_PER_TRACK = 9,
  parameter int SIDES             = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [6:0]  i_req_track,
  input  logic        i_req_side,
  input  logic [3:0]  i_req_sector,
  input  logic        i_img_mounted,
  input  logic [31:0] i_img_size,
  input  logic        i_img_readonly,
  output logic [31:0] o_sd_lba,
  output logic        o_sd_rd,
  output logic        o_sd_wr,
  input  logic        i_sd_ack,
  input  logic [8:0]  i_sd_buff_addr,
  input  logic [7:0]  i_sd_buff_din,
  input  logic        i_sd_buff_wr,
  output logic [7:0]  o_sd_buff_dout,
  output logic        o_rd_valid,
  output logic [7:0]  o_rd_data,
  input  logic        i_rd_ready,
  input  logic        i_wr_valid,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  output logic        o_done,
  output logic        o_err_rnf,
  output logic        o_err_wp
);

  localparam int IW = $clog2(SECTOR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SD_RD, S_STREAM, S_FILL, S_SD_WR, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic          r_run, r_write, r_side, r_acked, r_rd_valid, r_err_rnf, r_err_wp;
  logic [6:0]    r_track;
  logic [3:0]    r_sector;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_sd_lba;
  logic [7:0]    r_rd_data, r_sd_buff_dout;
  logic [7:0]    r_buf [SECTOR_BYTES];

  logic [31:0]   w_lba, w_end;
  logic [IW-1:0] w_rd_addr;
  logic          w_accept, w_rd_fire, w_wr_fire, w_last;
  logic          w_set_rnf, w_set_wp, w_sd_rd, w_sd_wr;

  assign w_lba = (32'(r_track) * 32'(SIDES) + 32'(r_side)) * 32'(SECTORS_PER_TRACK)
               + 32'(r_sector) - 32'd1;
  assign w_end     = (w_lba + 32'd1) * 32'(SECTOR_BYTES);
  assign w_accept  = i_req_valid & o_req_ready;
  assign w_last    = (r_idx == IW'(SECTOR_BYTES - 1));
  assign w_rd_fire = (r_state == S_STREAM) & r_rd_valid & i_rd_ready;
  assign w_wr_fire = (r_state == S_FILL) & i_wr_valid;
  // Prefetch the following byte on a handshake so the stream sustains 1 byte/cycle.
  assign w_rd_addr = w_rd_fire ? r_idx + IW'(1) : r_idx;

  always_comb begin
    w_next    = r_state;
    w_set_rnf = 1'b0;
    w_set_wp  = 1'b0;
    w_sd_rd   = 1'b0;
    w_sd_wr   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CHECK;
      S_CHECK: begin
        if (!i_img_mounted || r_sector == 4'd0 ||
            32'(r_sector) > 32'(SECTORS_PER_TRACK) || w_end > i_img_size) begin
          w_set_rnf = 1'b1;
          w_next    = S_DONE;
        end else if (r_write && i_img_readonly) begin
          w_set_wp = 1'b1;
          w_next   = S_DONE;
        end else begin
          w_next = r_write ? S_FILL : S_SD_RD;
        end
      end
      S_SD_RD, S_SD_WR: begin
        w_sd_rd = (r_state == S_SD_RD) & ~r_acked & (i_img_mounted | i_sd_ack);
        w_sd_wr = (r_state == S_SD_WR) & ~r_acked & (i_img_mounted | i_sd_ack);
        // An unmount only takes effect once the SD side is idle.
        if (!i_sd_ack && !i_img_mounted) begin
          w_set_rnf = 1'b1;
          w_next    = S_DONE;
        end else if (r_acked && !i_sd_ack) begin
          w_next = (r_state == S_SD_RD) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (!i_img_mounted) begin
          w_set_rnf = 1'b1;
          w_next    = S_DONE;
        end else if (w_rd_fire && w_last) begin
          w_next = S_DONE;
        end
      end
      S_FILL: begin
        if (!i_img_mounted) begin
          w_set_rnf = 1'b1;
          w_next    = S_DONE;
        end else if (w_wr_fire && w_last) begin
          w_next = S_SD_WR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_run          <= 1'b0;
      r_write        <= 1'b0;
      r_track        <= '0;
      r_side         <= 1'b0;
      r_sector       <= '0;
      r_idx          <= '0;
      r_sd_lba       <= '0;
      r_acked        <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_sd_buff_dout <= '0;
      r_err_rnf      <= 1'b0;
      r_err_wp       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (w_accept) begin
        r_write  <= i_req_write;
        r_track  <= i_req_track;
        r_side   <= i_req_side;
        r_sector <= i_req_sector;
      end
      if (r_state == S_CHECK) begin
        r_idx <= '0;
        if (w_next == S_SD_RD || w_next == S_FILL) r_sd_lba <= w_lba;
      end else if (w_rd_fire || w_wr_fire) begin
        r_idx <= r_idx + IW'(1);
      end
      r_acked    <= ((r_state == S_SD_RD) || (r_state == S_SD_WR)) & (r_acked | i_sd_ack);
      r_rd_valid <= (r_state == S_STREAM) && (w_next == S_STREAM);
      if (r_state == S_STREAM) r_rd_data <= r_buf[w_rd_addr];
      if (r_state == S_SD_WR) r_sd_buff_dout <= r_buf[i_sd_buff_addr];
      if (r_state == S_DONE || r_state == S_IDLE) begin
        r_err_rnf <= 1'b0;
        r_err_wp  <= 1'b0;
      end else begin
        if (w_set_rnf) r_err_rnf <= 1'b1;
        if (w_set_wp)  r_err_wp  <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == S_SD_RD && i_sd_ack && i_sd_buff_wr)
      r_buf[i_sd_buff_addr] <= i_sd_buff_din;
    else if (w_wr_fire)
      r_buf[r_idx] <= i_wr_data;
  end

  assign o_req_ready    = r_run & (r_state == S_IDLE);
  assign o_sd_lba       = r_sd_lba;
  assign o_sd_rd        = w_sd_rd;
  assign o_sd_wr        = w_sd_wr;
  assign o_sd_buff_dout = r_sd_buff_dout;
  assign o_rd_valid     = r_rd_valid;
  assign o_rd_data      = r_rd_data;
  assign o_wr_ready     = (r_state == S_FILL);
  assign o_done         = (r_state == S_DONE);
  assign o_err_rnf      = r_err_rnf;
  assign o_err_wp       = r_err_wp;

endmodule
